// File: rtl/mips_cpu_mem_arbiter_if.sv
// mips_cpu_mem_arbiter_if
// Groups the CPU-side instruction and data ports and the unified memory bus
// that mips_cpu_mem_arbiter connects.
//
// Modports:
//   master : the arbiter's view. It takes requests from the CPU, drives the
//            memory bus, and returns acks and read data.
//   slave  : the environment's view (CPU core plus memory). It drives requests,
//            bus_readdata and bus_waitrequest.
//
// Signal summary:
//   instr_read/instr_address          fetch request (held until instr_ack)
//   instr_ack/instr_readdata          fetch completion pulse and registered word
//   data_read/data_write/data_*       load/store request (held until data_ack)
//   data_ack/data_readdata            data completion pulse and registered word
//   bus_*                             waitrequest-style single-port memory bus
interface mips_cpu_mem_arbiter_if;
  logic        instr_read;
  logic [31:0] instr_address;
  logic        instr_ack;
  logic [31:0] instr_readdata;

  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic        data_ack;
  logic [31:0] data_readdata;

  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata;
  logic [31:0] bus_readdata;
  logic        bus_waitrequest;

  modport master (
    input  instr_read, instr_address,
    output instr_ack, instr_readdata,
    input  data_read, data_write, data_address, data_writedata, data_byteenable,
    output data_ack, data_readdata,
    output bus_address, bus_read, bus_write, bus_byteenable, bus_writedata,
    input  bus_readdata, bus_waitrequest
  );

  modport slave (
    output instr_read, instr_address,
    input  instr_ack, instr_readdata,
    output data_read, data_write, data_address, data_writedata, data_byteenable,
    input  data_ack, data_readdata,
    input  bus_address, bus_read, bus_write, bus_byteenable, bus_writedata,
    output bus_readdata, bus_waitrequest
  );
endinterface

// File: rtl/mips_cpu_mem_arbiter.sv
// mips_cpu_mem_arbiter
// Shares one waitrequest-style memory bus between the CPU instruction-fetch
// port and the data (load/store) port. A granted request is latched onto the
// bus and held until the memory drops waitrequest. The requester then gets a
// one-cycle ack, and read data is returned in a register.
//
// Parameters:
//   DATA_FIRST : 1 = the first contention after reset goes to data, 0 = instruction
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   arb   : mips_cpu_mem_arbiter_if.master (CPU ports and memory bus)
//   busy  : high while an access is on the bus
module mips_cpu_mem_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  mips_cpu_mem_arbiter_if.master        arb,
  output logic                          busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUS  = 1'b1;

  localparam logic GRANT_INSTR = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  logic [0:0]  state;
  logic        last_grant;
  logic        owner;
  logic [31:0] bus_address_r;
  logic [31:0] bus_writedata_r;
  logic [3:0]  bus_byteenable_r;
  logic        bus_read_r;
  logic        bus_write_r;
  logic        instr_ack_r;
  logic        data_ack_r;
  logic [31:0] instr_readdata_r;
  logic [31:0] data_readdata_r;

  logic data_req;
  logic instr_req;
  logic pick_data;

  // A port whose ack is showing this cycle is still holding its old request,
  // so it is masked out to avoid serving the same access twice.
  assign data_req  = (arb.data_read | arb.data_write) & ~data_ack_r;
  assign instr_req = arb.instr_read & ~instr_ack_r;

  // Data wins when it is alone, or when both want the bus and instruction
  // had the previous grant.
  assign pick_data = data_req & (~instr_req | (last_grant == GRANT_INSTR));

  // Main arbitration FSM. The bus outputs are registered at the grant edge and
  // stay frozen until the memory accepts the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      last_grant       <= DATA_FIRST ? GRANT_INSTR : GRANT_DATA;
      owner            <= GRANT_INSTR;
      bus_address_r    <= '0;
      bus_writedata_r  <= '0;
      bus_byteenable_r <= '0;
      bus_read_r       <= 1'b0;
      bus_write_r      <= 1'b0;
      instr_ack_r      <= 1'b0;
      data_ack_r       <= 1'b0;
      instr_readdata_r <= '0;
      data_readdata_r  <= '0;
    end else begin
      instr_ack_r <= 1'b0;
      data_ack_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_data) begin
            bus_address_r    <= arb.data_address;
            bus_writedata_r  <= arb.data_writedata;
            bus_byteenable_r <= arb.data_byteenable;
            // Read and write together is treated as a write.
            bus_write_r      <= arb.data_write;
            bus_read_r       <= arb.data_read & ~arb.data_write;
            owner            <= GRANT_DATA;
            last_grant       <= GRANT_DATA;
            state            <= BUS;
          end else if (instr_req) begin
            bus_address_r    <= arb.instr_address;
            bus_writedata_r  <= '0;
            bus_byteenable_r <= 4'b1111;
            bus_write_r      <= 1'b0;
            bus_read_r       <= 1'b1;
            owner            <= GRANT_INSTR;
            last_grant       <= GRANT_INSTR;
            state            <= BUS;
          end
        end
        BUS: begin
          if (!arb.bus_waitrequest) begin
            bus_read_r  <= 1'b0;
            bus_write_r <= 1'b0;
            state       <= IDLE;
            if (owner == GRANT_DATA) begin
              data_ack_r <= 1'b1;
              if (bus_read_r) begin
                data_readdata_r <= arb.bus_readdata;
              end
            end else begin
              instr_ack_r      <= 1'b1;
              instr_readdata_r <= arb.bus_readdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb.bus_address    = bus_address_r;
  assign arb.bus_writedata  = bus_writedata_r;
  assign arb.bus_byteenable = bus_byteenable_r;
  assign arb.bus_read       = bus_read_r;
  assign arb.bus_write      = bus_write_r;
  assign arb.instr_ack      = instr_ack_r;
  assign arb.data_ack       = data_ack_r;
  assign arb.instr_readdata = instr_readdata_r;
  assign arb.data_readdata  = data_readdata_r;
  assign busy               = (state == BUS);

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// tb_mips_cpu_mem_arbiter
// Self-checking bench for mips_cpu_mem_arbiter. It contains a small word
// memory with a programmable waitrequest, a table of single-access vectors,
// hand-written multi-cycle sequences, and a randomized two-port phase that is
// checked against a word-level memory model.
module tb_mips_cpu_mem_arbiter;

  logic clk;
  logic reset;
  logic busy;

  mips_cpu_mem_arbiter_if arb_if ();

  mips_cpu_mem_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (arb_if),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory environment: 16 words indexed by address[5:2].
  logic [31:0] mem [16];
  logic [31:0] model [16];
  int wait_cfg    = 0;
  bit random_wait = 1'b0;
  int wait_left   = 0;
  bit in_access   = 1'b0;

  logic [31:0] cur_instr_rd;
  logic [31:0] cur_data_rd;

  typedef struct {
    bit          is_data;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    bit          preload;
    logic [31:0] mem_word;
    bit          exp_read;
    bit          exp_write;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_latency;
    logic [31:0] exp_instr_rd;
    logic [31:0] exp_data_rd;
  } vec_t;

  vec_t vecs [8];

  // Memory responder: waitrequest is held high for a set number of cycles at
  // the start of each access; read data always reflects the addressed word.
  always @(negedge clk) begin
    if (arb_if.bus_read || arb_if.bus_write) begin
      if (!in_access) begin
        in_access = 1'b1;
        wait_left = random_wait ? int'($urandom_range(0, 3)) : wait_cfg;
      end else if (wait_left > 0) begin
        wait_left--;
      end
      arb_if.bus_waitrequest = (wait_left > 0);
      arb_if.bus_readdata    = mem[arb_if.bus_address[5:2]];
    end else begin
      in_access              = 1'b0;
      arb_if.bus_waitrequest = 1'($urandom_range(0, 1));
      arb_if.bus_readdata    = $urandom;
    end
  end

  // Memory commits a store at the edge where it accepts the access.
  always @(posedge clk) begin
    if (!reset && arb_if.bus_write && !arb_if.bus_waitrequest) begin
      for (int b = 0; b < 4; b++) begin
        if (arb_if.bus_byteenable[b]) begin
          mem[arb_if.bus_address[5:2]][8*b +: 8] = arb_if.bus_writedata[8*b +: 8];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic clearRequests();
    arb_if.instr_read = 1'b0;
    arb_if.data_read  = 1'b0;
    arb_if.data_write = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.is_data) begin
      arb_if.instr_read      = 1'b0;
      arb_if.data_read       = v.rd;
      arb_if.data_write      = v.wr;
      arb_if.data_address    = v.addr;
      arb_if.data_writedata  = v.wdata;
      arb_if.data_byteenable = v.be;
    end else begin
      arb_if.instr_read      = 1'b1;
      arb_if.instr_address   = v.addr;
      arb_if.data_read       = 1'b0;
      arb_if.data_write      = 1'b0;
      arb_if.data_writedata  = 32'hA5A5A5A5;
      arb_if.data_byteenable = 4'h5;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".bus_read"},       32'(arb_if.bus_read), 32'd0);
    checkOutput({tag, ".bus_write"},      32'(arb_if.bus_write), 32'd0);
    checkOutput({tag, ".instr_ack"},      32'(arb_if.instr_ack), 32'd0);
    checkOutput({tag, ".data_ack"},       32'(arb_if.data_ack), 32'd0);
    checkOutput({tag, ".busy"},           32'(busy), 32'd0);
    checkOutput({tag, ".bus_address"},    arb_if.bus_address, 32'd0);
    checkOutput({tag, ".bus_writedata"},  arb_if.bus_writedata, 32'd0);
    checkOutput({tag, ".bus_byteenable"}, 32'(arb_if.bus_byteenable), 32'd0);
    checkOutput({tag, ".instr_readdata"}, arb_if.instr_readdata, 32'd0);
    checkOutput({tag, ".data_readdata"},  arb_if.data_readdata, 32'd0);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    clearRequests();
    @(negedge clk);
    @(negedge clk);
    reset        = 1'b0;
    cur_instr_rd = '0;
    cur_data_rd  = '0;
  endtask

  // One complete access: bus outputs checked every strobe cycle, then the
  // ack latency, the ack owner, both readdata registers and the single-cycle ack.
  task automatic runVector(input vec_t v, input string tag);
    int cyc;
    int strobe_cycles;
    bit acked;
    wait_cfg = v.waits;
    if (v.preload) mem[v.addr[5:2]] = v.mem_word;
    @(negedge clk);
    applyStimulus(v);
    cyc = 0;
    strobe_cycles = 0;
    acked = 1'b0;
    while (!acked && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (arb_if.bus_read || arb_if.bus_write) begin
        strobe_cycles++;
        checkOutput({tag, ".bus_address"},    arb_if.bus_address, v.addr);
        checkOutput({tag, ".bus_read"},       32'(arb_if.bus_read), 32'(v.exp_read));
        checkOutput({tag, ".bus_write"},      32'(arb_if.bus_write), 32'(v.exp_write));
        checkOutput({tag, ".bus_byteenable"}, 32'(arb_if.bus_byteenable), 32'(v.exp_be));
        checkOutput({tag, ".bus_writedata"},  arb_if.bus_writedata, v.exp_wdata);
        checkOutput({tag, ".busy"},           32'(busy), 32'd1);
        checkOutput({tag, ".instr_rd_hold"},  arb_if.instr_readdata, cur_instr_rd);
        checkOutput({tag, ".data_rd_hold"},   arb_if.data_readdata, cur_data_rd);
      end
      if (arb_if.instr_ack || arb_if.data_ack) acked = 1'b1;
    end
    checkOutput({tag, ".ack_seen"},       32'(acked), 32'd1);
    checkOutput({tag, ".latency"},        32'(cyc), 32'(v.exp_latency));
    checkOutput({tag, ".strobe_cycles"},  32'(strobe_cycles), 32'(v.exp_latency - 1));
    checkOutput({tag, ".instr_ack"},      32'(arb_if.instr_ack), 32'(!v.is_data));
    checkOutput({tag, ".data_ack"},       32'(arb_if.data_ack), 32'(v.is_data));
    checkOutput({tag, ".instr_readdata"}, arb_if.instr_readdata, v.exp_instr_rd);
    checkOutput({tag, ".data_readdata"},  arb_if.data_readdata, v.exp_data_rd);
    cur_instr_rd = v.exp_instr_rd;
    cur_data_rd  = v.exp_data_rd;
    clearRequests();
    @(negedge clk);
    checkOutput({tag, ".ack_one_cycle"}, 32'(arb_if.instr_ack | arb_if.data_ack), 32'd0);
    checkOutput({tag, ".no_reaccess"},   32'(arb_if.bus_read | arb_if.bus_write), 32'd0);
  endtask

  task automatic instrDriver(input int n);
    logic [31:0] r;
    logic [3:0]  idx;
    bit          got;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      r   = $urandom;
      idx = 4'($urandom_range(0, 7));
      arb_if.instr_address = {r[31:6], idx, 2'b00};
      arb_if.instr_read    = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (arb_if.instr_ack) got = 1'b1;
      end
      checkOutput("rand.instr_ack", 32'(got), 32'd1);
      if (got) checkOutput("rand.instr_readdata", arb_if.instr_readdata, model[idx]);
      arb_if.instr_read = 1'b0;
    end
  endtask

  task automatic dataDriver(input int n);
    logic [31:0] r;
    logic [31:0] wd;
    logic [3:0]  idx;
    logic [3:0]  be;
    bit          wr;
    bit          rd;
    bit          got;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      r   = $urandom;
      wd  = $urandom;
      idx = 4'(8 + $urandom_range(0, 7));
      be  = 4'($urandom_range(1, 15));
      wr  = 1'($urandom_range(0, 1));
      rd  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      arb_if.data_address    = {r[31:6], idx, 2'b00};
      arb_if.data_writedata  = wd;
      arb_if.data_byteenable = be;
      arb_if.data_read       = rd;
      arb_if.data_write      = wr;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (arb_if.data_ack) got = 1'b1;
      end
      checkOutput("rand.data_ack", 32'(got), 32'd1);
      if (got) begin
        if (wr) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
          end
          checkOutput("rand.store_keeps_readdata", arb_if.data_readdata, cur_data_rd);
        end else begin
          checkOutput("rand.data_readdata", arb_if.data_readdata, model[idx]);
          cur_data_rd = model[idx];
        end
      end
      arb_if.data_read  = 1'b0;
      arb_if.data_write = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int ack_cycles [$];
    bit ack_is_data [$];
    int strobes;
    int acks;
    bit got;

    clk   = 1'b0;
    reset = 1'b1;
    arb_if.instr_read      = 1'b0;
    arb_if.instr_address   = '0;
    arb_if.data_read       = 1'b0;
    arb_if.data_write      = 1'b0;
    arb_if.data_address    = '0;
    arb_if.data_writedata  = '0;
    arb_if.data_byteenable = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    cur_instr_rd = '0;
    cur_data_rd  = '0;

    //            data rd wr addr            wdata         be       waits pre mem_word      eR eW eBE      eWD           lat eInstr        eData
    vecs[0] = '{1'b0, 1, 0, 32'hBFC00000, 32'h0,        4'h0,    0,    1,  32'h24020005, 1, 0, 4'hF,    32'h0,        2, 32'h24020005, 32'h0};
    vecs[1] = '{1'b1, 1, 0, 32'h00001000, 32'h0,        4'hF,    3,    1,  32'h11223344, 1, 0, 4'hF,    32'h0,        5, 32'h24020005, 32'h11223344};
    vecs[2] = '{1'b1, 0, 1, 32'h00000010, 32'hDEADBEEF, 4'b0011, 1,    0,  32'h0,        0, 1, 4'b0011, 32'hDEADBEEF, 3, 32'h24020005, 32'h11223344};
    vecs[3] = '{1'b1, 1, 1, 32'h00000020, 32'hCAFEF00D, 4'hF,    0,    0,  32'h0,        0, 1, 4'hF,    32'hCAFEF00D, 2, 32'h24020005, 32'h11223344};
    vecs[4] = '{1'b1, 1, 0, 32'h00000010, 32'h0,        4'b1100, 0,    0,  32'h0,        1, 0, 4'b1100, 32'h0,        2, 32'h24020005, 32'h0000BEEF};
    vecs[5] = '{1'b1, 1, 0, 32'h00000020, 32'h0,        4'hF,    0,    0,  32'h0,        1, 0, 4'hF,    32'h0,        2, 32'h24020005, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 1, 0, 32'h00000024, 32'h0,        4'h0,    2,    1,  32'h8FBF0010, 1, 0, 4'hF,    32'h0,        4, 32'h8FBF0010, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 1, 0, 32'hBFC00004, 32'h0,        4'h0,    0,    1,  32'h00851021, 1, 0, 4'hF,    32'h0,        2, 32'h00851021, 32'h0};

    @(negedge clk);
    checkResetValues("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Continuous contention from a fresh reset: data first, then alternating,
    // one access every two cycles.
    resetDut();
    wait_cfg = 0;
    mem[0] = 32'h3C1DBFC0;
    mem[1] = 32'h8C880004;
    arb_if.instr_address   = 32'h00000040;
    arb_if.data_address    = 32'h00000044;
    arb_if.data_byteenable = 4'hF;
    arb_if.instr_read      = 1'b1;
    arb_if.data_read       = 1'b1;
    cyc = 0;
    while (ack_cycles.size() < 4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      checkOutput("rr.no_double_ack", 32'(arb_if.instr_ack & arb_if.data_ack), 32'd0);
      if (arb_if.data_ack) begin
        ack_cycles.push_back(cyc);
        ack_is_data.push_back(1'b1);
      end else if (arb_if.instr_ack) begin
        ack_cycles.push_back(cyc);
        ack_is_data.push_back(1'b0);
      end
    end
    clearRequests();
    checkOutput("rr.ack_count", 32'(ack_cycles.size()), 32'd4);
    if (ack_cycles.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("rr.grant%0d_is_data", k), 32'(ack_is_data[k]), 32'((k % 2) == 0));
        checkOutput($sformatf("rr.ack%0d_cycle", k), 32'(ack_cycles[k]), 32'(2 * k + 2));
      end
    end
    checkOutput("rr.instr_readdata", arb_if.instr_readdata, 32'h3C1DBFC0);
    checkOutput("rr.data_readdata",  arb_if.data_readdata,  32'h8C880004);
    cur_instr_rd = 32'h3C1DBFC0;
    cur_data_rd  = 32'h8C880004;
    repeat (2) @(negedge clk);

    // Load held through its ack cycle with instruction idle: one access only.
    arb_if.data_read = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (arb_if.data_ack) got = 1'b1;
    end
    checkOutput("hold.first_ack", 32'(got), 32'd1);
    @(negedge clk);
    checkOutput("hold.no_regrant", 32'(arb_if.bus_read | arb_if.bus_write), 32'd0);
    arb_if.data_read = 1'b0;
    strobes = 0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (arb_if.bus_read || arb_if.bus_write) strobes++;
      if (arb_if.data_ack || arb_if.instr_ack) acks++;
    end
    checkOutput("hold.idle_strobes", 32'(strobes), 32'd0);
    checkOutput("hold.idle_acks",    32'(acks), 32'd0);
    arb_if.data_read = 1'b1;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (arb_if.data_ack) got = 1'b1;
    end
    checkOutput("hold.reassert_ack",     32'(got), 32'd1);
    checkOutput("hold.reassert_latency", 32'(cyc), 32'd2);
    arb_if.data_read = 1'b0;
    @(negedge clk);

    // Reset in the middle of a stalled load: strobe drops at once, no ack.
    wait_cfg = 100;
    arb_if.data_address = 32'h00001000;
    arb_if.data_read    = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_mid.bus_read_before", 32'(arb_if.bus_read), 32'd1);
    checkOutput("rst_mid.busy_before",     32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("rst_mid");
    clearRequests();
    @(negedge clk);
    reset        = 1'b0;
    wait_cfg     = 0;
    cur_instr_rd = '0;
    cur_data_rd  = '0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (arb_if.data_ack || arb_if.instr_ack) acks++;
    end
    checkOutput("rst_mid.no_ack", 32'(acks), 32'd0);
    runVector(vecs[7], "post_reset");

    // Randomized concurrent traffic on both ports against the word model.
    resetDut();
    random_wait = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem[i]   = $urandom;
      model[i] = mem[i];
    end
    fork
      instrDriver(40);
      dataDriver(40);
    join
    random_wait = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_cpu_mem_arbiter.md
# mips_cpu_mem_arbiter

Shares one single-port, waitrequest-style memory bus between the CPU's instruction-fetch port and its data (load/store) port. The block latches each request and drives it onto the bus until the memory accepts it. It then returns the read data and a one-cycle acknowledge to the requester that issued the access. It sits between the Harvard-style CPU core and a unified memory, turning two combinational memory interfaces into one stalling bus.

## Interface
- DATA_FIRST, default 1: on the first contention after reset, 1 grants data, 0 grants instruction.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_read  in  1  instruction-fetch request; held until instr_ack.
- instr_address  in  32  fetch address; stable while instr_read is high.
- instr_ack  out  1  one-cycle pulse: fetch complete, instr_readdata valid.
- instr_readdata  out  32  registered fetched word; holds its value until the next fetch completes.
- data_read  in  1  load request; held until data_ack.
- data_write  in  1  store request; held until data_ack.
- data_address  in  32  load/store address.
- data_writedata  in  32  store data.
- data_byteenable  in  4  store/load byte lanes.
- data_ack  out  1  one-cycle pulse: data access complete.
- data_readdata  out  32  registered load word; holds until the next data read completes.
- bus_address  out  32  memory address.
- bus_read  out  1  memory read strobe.
- bus_write  out  1  memory write strobe.
- bus_byteenable  out  4  memory byte lanes.
- bus_writedata  out  32  memory write data.
- bus_readdata  in  32  memory read data; valid in the cycle where waitrequest is low during a read.
- bus_waitrequest  in  1  high means the memory has not accepted the access; bus outputs must be held.
- busy  out  1  high in BUS state.

## Operation
- States: IDLE, BUS. Register last_grant ∈ {INSTR, DATA}.
- Pending request definitions:
  - data_req = (data_read | data_write) & ~data_ack.
  - instr_req = instr_read & ~instr_ack.
  - A port whose ack is high in the current cycle is ignored, so a held request is never double-served.
- IDLE behaviour:
  - No request pending: stay in IDLE; all bus strobes low.
  - One request pending: grant it.
  - Both pending: grant the port not equal to last_grant (round-robin).
- On a grant:
  - Register bus_address, byteenable, writedata and strobe from the winner.
  - Instruction grants use byteenable 4'b1111, bus_read=1, bus_writedata=0.
  - Set last_grant to the winner; go to BUS.
- Data port with read and write both high: illegal. Perform the write, ignore the read.
- BUS behaviour:
  - Bus outputs are held constant.
  - At the rising edge where bus_waitrequest=0, the access completes.
  - On completion: drop the strobes, pulse the winner's ack for the next cycle, and go to IDLE.
  - Reads capture bus_readdata into the winner's readdata register.
  - Writes leave both readdata registers unchanged.
- No timeout: BUS waits indefinitely while bus_waitrequest=1.

## Timing
- Reset values:
  - State IDLE; last_grant = INSTR if DATA_FIRST=1, otherwise DATA.
  - bus_read, bus_write, instr_ack, data_ack, busy = 0.
  - bus_address, bus_writedata, instr_readdata, data_readdata = 0; bus_byteenable = 0.
- Reset asserted mid-access: strobes drop immediately (asynchronous). No ack is issued and the access is abandoned.
- Request high at edge N with waitrequest 0: bus strobe is high between edges N and N+1, and ack is high between edges N+1 and N+2. Minimum latency from request sampled to ack is 2 cycles.
- Each waitrequest-high cycle adds one cycle of latency.
- Ack is high for exactly 1 cycle.
- The arbiter is in IDLE during the ack cycle, so a different pending request can be granted in that same cycle. Back-to-back throughput is 1 access per 2 cycles.
- A requester may assert a new request in the cycle after its ack.
- Requests that change while not yet granted are sampled only at the grant edge.

## Test plan
- Fetch at 0xBFC00000, bus_readdata=0x24020005, waitrequest 0 -> bus_read with byteenable 4'hF one cycle after the request; instr_ack pulses one cycle later; instr_readdata=0x24020005.
- Load at 0x00001000, waitrequest held high 3 cycles -> bus outputs stable for 4 cycles; data_ack pulses once; data_readdata captured only at the release edge.
- Store 0xDEADBEEF, byteenable 4'b0011, to 0x10 -> bus_write=1, bus_writedata=0xDEADBEEF; data_ack pulses; instr_readdata and data_readdata unchanged.
- Instr and data requested together continuously, DATA_FIRST=1 -> grant order DATA, INSTR, DATA, INSTR; each ack occurs exactly once per grant.
- Request held during its ack cycle with the other port idle -> no second bus access until the requester re-asserts its request.
- Reset asserted while in BUS with waitrequest high -> bus_read falls asynchronously; no ack; all outputs at reset values; the next request is served normally.
